ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_ctrl_pkg.sv | 14 +
 rtl/rr_arb2.sv | 41 ++++
 rtl/ram_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the RAM arbiter slice.
package ram_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 24;
    localparam int unsigned DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a pointer naming the preferred port.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant: pointer port on contention, otherwise whichever port asks.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
        // Preference passes to the port that was not just served.
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    // Pointer register, port 0 preferred out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of an asynchronous single-port RAM.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_we,
    input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                 rsp_valid,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    inout  wire  [DATA_WIDTH-1:0]      mem_data,
    output logic                       mem_cs,
    output logic                       mem_we,
    output logic                       mem_oe
);

    state_t                  state_q, state_d;
    logic                    id_q, id_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              gnt;
    logic                    drive_en;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (rst_n && (state_q == IDLE)),
        .req_i (req_valid),
        .gnt_o (gnt)
    );

    // Next-state and request latching.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    id_d    = gnt[1];
                    we_d    = req_we[gnt[1]];
                    addr_d  = req_addr[gnt[1]];
                    wdata_d = req_wdata[gnt[1]];
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = we_q ? RESP : CAPTURE;
            CAPTURE: begin
                rdata_d = mem_data;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and handshakes; gated by rst_n so a reset cycle never
    // strobes the RAM or signals a handshake.
    always_comb begin
        req_ready = gnt;
        rsp_valid = '0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_oe    = 1'b0;
        if (rst_n) begin
            case (state_q)
                ACCESS: begin
                    mem_cs = 1'b1;
                    mem_we = we_q;
                    mem_oe = !we_q;
                end
                CAPTURE: begin
                    mem_cs = 1'b1;
                    mem_oe = 1'b1;
                end
                RESP:    rsp_valid[id_q] = 1'b1;
                default: ;
            endcase
        end
        drive_en = mem_cs && mem_we;
    end

    assign mem_addr  = addr_q;
    assign rsp_rdata = rdata_q;
    assign mem_data  = drive_en ? wdata_q : 'z;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
